// File: rtl/cache_controller_if.sv
// CPU-side and line-adapter-side signal bundle for cache_controller.
// The slave modport is the controller view; master is the CPU/adapter (bench) view.
interface cache_controller_if;
    logic [31:0]  cpuAddr;
    logic         cpuRe;
    logic         cpuWe;
    logic [31:0]  cpuWdata;
    logic [3:0]   cpuBe;
    logic [31:0]  cpuRdata;
    logic         cpuStall;
    logic         adapterRe;
    logic         adapterWe;
    logic         adapterReady;
    logic [255:0] lineFromMem;
    logic [255:0] lineToMem;
    logic [31:0]  memAddr;
    logic [15:0]  hitCount;
    logic [15:0]  missCount;

    modport slave (
        input  cpuAddr, cpuRe, cpuWe, cpuWdata, cpuBe, adapterReady, lineFromMem,
        output cpuRdata, cpuStall, adapterRe, adapterWe, lineToMem, memAddr, hitCount, missCount
    );

    modport master (
        output cpuAddr, cpuRe, cpuWe, cpuWdata, cpuBe, adapterReady, lineFromMem,
        input  cpuRdata, cpuStall, adapterRe, adapterWe, lineToMem, memAddr, hitCount, missCount
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with 8-word (256-bit) lines.
// Misses evict a dirty victim through the line adapter, then refill and replay as a hit.
module cache_controller #(
    parameter int unsigned NUM_LINES = 16
) (
    input logic               CLK,
    input logic               RST,
    cache_controller_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_LINES);
    localparam int unsigned TagW = 27 - IdxW;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e               state_q, state_d;
    logic [255:0]         data_q [NUM_LINES];
    logic [TagW-1:0]      tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [15:0]          hit_count_q, hit_count_d;
    logic [15:0]          miss_count_q, miss_count_d;

    logic [IdxW-1:0] idx;
    logic [TagW-1:0] cpu_tag;
    logic [2:0]      word;
    logic [255:0]    cur_line;
    logic            req;
    logic            hit;
    logic            line_we;
    logic            tag_we;
    logic [255:0]    line_wdata;

    assign idx      = bus.cpuAddr[5 +: IdxW];
    assign cpu_tag  = bus.cpuAddr[31 -: TagW];
    assign word     = bus.cpuAddr[4:2];
    assign cur_line = data_q[idx];
    assign req      = bus.cpuRe | bus.cpuWe;
    assign hit      = valid_q[idx] && (tag_q[idx] == cpu_tag);

    assign bus.cpuRdata  = cur_line[32*word +: 32];
    assign bus.lineToMem = cur_line;
    assign bus.hitCount  = hit_count_q;
    assign bus.missCount = miss_count_q;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        line_we       = 1'b0;
        tag_we        = 1'b0;
        line_wdata    = cur_line;
        bus.cpuStall  = 1'b0;
        bus.adapterRe = 1'b0;
        bus.adapterWe = 1'b0;
        bus.memAddr   = {cpu_tag, idx, 5'b0};

        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    hit_count_d = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
                    // A write (including re+we together) merges the enabled bytes in place.
                    if (bus.cpuWe) begin
                        line_we = 1'b1;
                        dirty_d[idx] = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (bus.cpuBe[b]) begin
                                line_wdata[32*int'(word) + 8*b +: 8] = bus.cpuWdata[8*b +: 8];
                            end
                        end
                    end
                end else if (req) begin
                    bus.cpuStall = 1'b1;
                    miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                bus.cpuStall  = 1'b1;
                bus.adapterWe = 1'b1;
                bus.memAddr   = {tag_q[idx], idx, 5'b0};
                if (bus.adapterReady) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                bus.cpuStall  = 1'b1;
                bus.adapterRe = 1'b1;
                if (bus.adapterReady) begin
                    line_we      = 1'b1;
                    tag_we       = 1'b1;
                    line_wdata   = bus.lineFromMem;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            dirty_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Line data and tags carry no reset; the valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[idx] <= cpu_tag;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: transaction-level cache/memory model, adapter emulator with random
// latency, per-cycle monitor, directed scenarios and randomized traffic.
module tb_cache_controller;
    localparam int unsigned NL = 16;
    localparam int IW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    cache_controller_if bus ();

    cache_controller #(.NUM_LINES(NL)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] m_data  [NL];
    logic [26:0]  m_line  [NL];
    bit           m_valid [NL];
    bit           m_dirty [NL];
    int           m_hits = 0;
    int           m_miss = 0;
    logic [255:0] mem [logic [31:0]];

    logic [31:0]  exp_wb_addr = '0, exp_alloc_addr = '0;
    logic [255:0] exp_wb_line = '0;
    logic [31:0]  last_wb_addr = '0, last_alloc_addr = '0, last_rdata = '0;
    logic [255:0] last_wb_line = '0;
    bit           hold_ready = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] r;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < 8; w++) r[32*w +: 32] = a ^ (w * 32'h0101_0101) ^ 32'h5A5A_C3C3;
        return r;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Per-cycle protocol monitor against the expectations of the transaction in flight.
    always @(negedge CLK) begin
        #1;
        if (!RST) begin
            check("enables_exclusive", 1'(bus.adapterRe & bus.adapterWe), 1'b0);
            if (bus.adapterWe) begin
                check("wb_addr", bus.memAddr, exp_wb_addr);
                check("wb_line", bus.lineToMem, exp_wb_line);
                last_wb_addr = bus.memAddr;
                last_wb_line = bus.lineToMem;
            end
            if (bus.adapterRe) begin
                check("alloc_addr", bus.memAddr, exp_alloc_addr);
                last_alloc_addr = bus.memAddr;
            end
        end
    end

    // Line adapter: responds to a fetch or writeback after 0..3 extra cycles.
    initial begin
        int wait_cnt;
        int delay;
        wait_cnt = 0;
        delay = 1;
        bus.adapterReady = 1'b0;
        bus.lineFromMem = '0;
        forever begin
            @(negedge CLK);
            bus.adapterReady = 1'b0;
            if (bus.adapterWe || (bus.adapterRe && !hold_ready)) begin
                if (wait_cnt >= delay) begin
                    bus.adapterReady = 1'b1;
                    bus.lineFromMem = bus.adapterRe ? mem_line(bus.memAddr) : '0;
                    wait_cnt = 0;
                    delay = $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic set_exp(input logic [31:0] a);
        int idx;
        idx = int'(a[5 +: IW]);
        exp_wb_addr = {m_line[idx], 5'b0};
        exp_wb_line = m_data[idx];
        exp_alloc_addr = {a[31:5], 5'b0};
        if (m_valid[idx] && m_dirty[idx] && m_line[idx] != a[31:5]) mem[exp_wb_addr] = m_data[idx];
    endtask

    task automatic do_req(input logic [31:0] a, input bit re, input bit we,
                          input logic [31:0] wd, input logic [3:0] be);
        int  idx;
        int  w;
        bit  exp_hit, vdirty, saw_we, saw_re, done;
        idx = int'(a[5 +: IW]);
        w = int'(a[4:2]);
        exp_hit = m_valid[idx] && (m_line[idx] == a[31:5]);
        vdirty = !exp_hit && m_valid[idx] && m_dirty[idx];
        saw_we = 1'b0;
        saw_re = 1'b0;
        set_exp(a);
        @(negedge CLK);
        bus.cpuAddr = a;
        bus.cpuRe = re;
        bus.cpuWe = we;
        bus.cpuWdata = wd;
        bus.cpuBe = be;
        #1;
        check("stall_first", bus.cpuStall, !exp_hit);
        if (!exp_hit) begin
            done = 1'b0;
            for (int i = 0; i < 64; i++) begin
                @(negedge CLK);
                #1;
                saw_we |= bus.adapterWe;
                saw_re |= bus.adapterRe;
                if (!bus.cpuStall) begin
                    done = 1'b1;
                    break;
                end
            end
            check("refill_done", done, 1'b1);
            check("wb_seen", saw_we, vdirty);
            check("alloc_seen", saw_re, 1'b1);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_line[idx] = a[31:5];
            m_data[idx] = mem_line({a[31:5], 5'b0});
            m_miss = sat_inc(m_miss);
        end
        last_rdata = bus.cpuRdata;
        check("rdata", bus.cpuRdata, m_data[idx][32*w +: 32]);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[idx][32*w + 8*b +: 8] = wd[8*b +: 8];
            m_dirty[idx] = 1'b1;
        end
        m_hits = sat_inc(m_hits);
        @(negedge CLK);
        bus.cpuRe = 1'b0;
        bus.cpuWe = 1'b0;
        #1;
        check("hit_count", bus.hitCount, m_hits);
        check("miss_count", bus.missCount, m_miss);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        int           stall_bad, mode;
        bit           reached;

        for (int i = 0; i < NL; i++) begin
            m_data[i] = '0;
            m_line[i] = '0;
        end
        model_reset();
        l = mem_line(32'h100);
        l[63:32] = 32'hDEADBEEF;
        mem[32'h100] = l;

        bus.cpuAddr = '0;
        bus.cpuRe = 1'b0;
        bus.cpuWe = 1'b0;
        bus.cpuWdata = '0;
        bus.cpuBe = '0;
        #1 RST = 1'b1;
        #7;
        check("rst_adapterRe", bus.adapterRe, 1'b0);
        check("rst_adapterWe", bus.adapterWe, 1'b0);
        check("rst_hits", bus.hitCount, 16'h0);
        check("rst_miss", bus.missCount, 16'h0);
        check("idle_no_stall", bus.cpuStall, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Cold read with a known line in memory.
        do_req(32'h0000_0104, 1'b1, 1'b0, '0, '0);
        check("cold_alloc_addr", last_alloc_addr, 32'h0000_0100);
        check("cold_rdata", last_rdata, 32'hDEADBEEF);
        check("cold_miss", bus.missCount, 16'd1);
        check("cold_hit", bus.hitCount, 16'd1);

        // Partial write hit, then re-read.
        do_req(32'h0000_0104, 1'b0, 1'b1, 32'h1234_5678, 4'b0011);
        do_req(32'h0000_0104, 1'b1, 1'b0, '0, '0);
        check("merge_rdata", last_rdata, 32'hDEAD5678);

        // Dirty conflict: writeback of old line, then fetch.
        last_wb_addr = '0;
        last_wb_line = '0;
        do_req(32'h0000_2104, 1'b1, 1'b0, '0, '0);
        check("evict_addr", last_wb_addr, 32'h0000_0100);
        check("evict_word1", last_wb_line[63:32], 32'hDEAD5678);
        check("evict_alloc_addr", last_alloc_addr, 32'h0000_2100);

        // Clean conflict: straight to allocate (wb_seen must be 0 inside do_req).
        do_req(32'h0000_0104, 1'b1, 1'b0, '0, '0);
        check("refetched_word1", last_rdata, 32'hDEAD5678);

        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << (5 + IW)) | (32'($urandom_range(0, NL - 1)) << 5)
                | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
            mode = $urandom_range(0, 2);
            do_req(a, mode != 1, mode != 0, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of a refill.
        do_req(32'h0000_0104, 1'b1, 1'b0, '0, '0);
        hold_ready = 1'b1;
        set_exp(32'h0000_4104);
        @(negedge CLK);
        bus.cpuAddr = 32'h0000_4104;
        bus.cpuRe = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (bus.adapterRe) begin
                reached = 1'b1;
                break;
            end
        end
        check("alloc_reached", reached, 1'b1);
        #1 RST = 1'b1;
        #1;
        check("rst_async_re", bus.adapterRe, 1'b0);
        check("rst_async_we", bus.adapterWe, 1'b0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        bus.cpuRe = 1'b0;
        hold_ready = 1'b0;
        #1;
        check("post_rst_miss", bus.missCount, 16'd0);
        do_req(32'h0000_0104, 1'b1, 1'b0, '0, '0);
        check("post_rst_refetch", bus.missCount, 16'd1);

        // Saturate the hit counter by holding a hitting read.
        @(negedge CLK);
        bus.cpuAddr = 32'h0000_0104;
        bus.cpuRe = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 65600; i++) begin
            #1;
            if (bus.cpuStall) stall_bad++;
            @(negedge CLK);
        end
        bus.cpuRe = 1'b0;
        m_hits = (m_hits + 65600 > 65535) ? 65535 : m_hits + 65600;
        #1;
        check("hold_no_stall", stall_bad, 0);
        check("hit_saturated", bus.hitCount, 16'hFFFF);
        check("hit_sat_model", bus.hitCount, m_hits);
        do_req(32'h0000_0104, 1'b1, 1'b0, '0, '0);
        check("hit_stays_sat", bus.hitCount, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
